lsu_unit: RTL and testbench

Load/store unit sitting directly downstream of the address generation unit in the execute stage. It consumes the registered effective address and its valid strobe. It then performs one byte, halfword or word memory access over a simple req/gnt/rvalid data-memory port. For loads it returns an aligned, sign- or zero-extended result to writeback; for stores it returns a completion pulse.

---
 rtl/lsu_unit_if.sv | 24 ++
 rtl/lsu_unit.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Data-memory port of the load/store unit: a request/grant channel for the
// address phase and a read-valid channel for returned load data.
interface lsu_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one effective address from the AGU, performs a
// single byte/halfword/word access on the data-memory port and returns either
// an extended load result, a store completion pulse or a misalignment fault.
module lsu_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] agu_addr,
  input  logic                  agu_valid,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd_tag,
  output logic                  ready,
  lsu_unit_if.master            mem,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [4:0]            load_tag,
  output logic                  load_valid,
  output logic                  store_done,
  output logic                  misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  is_store_q, is_store_d;
  logic [4:0]            tag_q, tag_d;

  logic                  ready_q, ready_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic [4:0]            load_tag_q, load_tag_d;
  logic                  load_valid_q, load_valid_d;
  logic                  store_done_q, store_done_d;
  logic                  misaligned_q, misaligned_d;

  logic                  illegal;
  logic [3:0]            be_acc;
  logic [DATA_WIDTH-1:0] wdata_acc;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] extracted;

  // Classify the incoming access: unsupported encodings, unsigned stores and
  // halfword/word accesses that do not sit on their natural boundary fault.
  always_comb begin
    case (funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = agu_addr[0];
      3'b010:  illegal = |agu_addr[1:0];
      3'b100:  illegal = is_store;
      3'b101:  illegal = is_store | agu_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Byte enables follow access size and the low address bits.
  always_comb begin
    case (funct3[1:0])
      2'b00:   be_acc = 4'b0001 << agu_addr[1:0];
      2'b01:   be_acc = agu_addr[1] ? 4'b1100 : 4'b0011;
      default: be_acc = 4'b1111;
    endcase
  end

  // Write data is replicated so the significant bytes land in every lane the
  // enables could select; memory picks the right copy through mem_be.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_acc[gi*8 +: 8] =
        (funct3[1:0] == 2'b00) ? store_data[7:0] :
        (funct3[1:0] == 2'b01) ? store_data[(gi%2)*8 +: 8] :
                                 store_data[gi*8 +: 8];
  end

  assign shifted = mem.rdata >> {lane_q, 3'b000};

  // Bring the addressed bytes to bit 0 and extend them to a full word.
  always_comb begin
    case (funct3_q)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extracted = {24'b0, shifted[7:0]};
      3'b101:  extracted = {16'b0, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  // Next-state and next-output logic; every output is derived from the state
  // being entered so all of them come straight from flops.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    funct3_d     = funct3_q;
    is_store_d   = is_store_q;
    tag_d        = tag_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_tag_d   = load_tag_q;

    case (state_q)
      S_IDLE: begin
        if (agu_valid) begin
          lane_d     = agu_addr[1:0];
          funct3_d   = funct3;
          is_store_d = is_store;
          tag_d      = rd_tag;
          if (illegal) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
            we_d    = is_store;
            addr_d  = {agu_addr[DATA_WIDTH-1:2], 2'b00};
            be_d    = be_acc;
            wdata_d = wdata_acc;
          end
        end
      end
      S_REQ: begin
        if (mem.gnt) state_d = is_store_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem.rvalid) begin
          load_data_d = extracted;
          load_tag_d  = tag_q;
          state_d     = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d      = (state_d == S_IDLE);
    req_d        = (state_d == S_REQ);
    store_done_d = (state_d == S_RESP) && is_store_d;
    load_valid_d = (state_d == S_RESP) && !is_store_d;
    misaligned_d = (state_d == S_FAULT);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      tag_q        <= '0;
      ready_q      <= 1'b1;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_tag_q   <= '0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      funct3_q     <= funct3_d;
      is_store_q   <= is_store_d;
      tag_q        <= tag_d;
      ready_q      <= ready_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_tag_q   <= load_tag_d;
      load_valid_q <= load_valid_d;
      store_done_q <= store_done_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign ready      = ready_q;
  assign mem.req    = req_q;
  assign mem.we     = we_q;
  assign mem.addr   = addr_q;
  assign mem.be     = be_q;
  assign mem.wdata  = wdata_q;
  assign load_data  = load_data_q;
  assign load_tag   = load_tag_q;
  assign load_valid = load_valid_q;
  assign store_done = store_done_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Testbench for lsu_unit: directed and random accesses against a
// transaction-level model; expected outputs are checked every cycle.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] agu_addr = '0;
  logic        agu_valid = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_tag = '0;
  logic        ready;
  logic [31:0] load_data;
  logic [4:0]  load_tag;
  logic        load_valid;
  logic        store_done;
  logic        misaligned;

  lsu_unit_if #(.DATA_WIDTH(32)) mem_if ();

  lsu_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .agu_addr   (agu_addr),
    .agu_valid  (agu_valid),
    .is_store   (is_store),
    .funct3     (funct3),
    .store_data (store_data),
    .rd_tag     (rd_tag),
    .ready      (ready),
    .mem        (mem_if),
    .load_data  (load_data),
    .load_tag   (load_tag),
    .load_valid (load_valid),
    .store_done (store_done),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        st;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] sd;
    bit [4:0]  tag;
    int        stall;
    int        rvd;
    bit [31:0] rdata;
    bit        rv_in_req;
    bit        hold;
  } op_t;

  op_t ops[$];

  int n_pass  = 0;
  int n_total = 0;

  // Expected outputs, updated by the driver from the access rules.
  logic        cmp_en = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_req = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_lv = 1'b0;
  logic [31:0] exp_ld = '0;
  logic [4:0]  exp_tag = '0;
  logic        exp_sd = 1'b0;
  logic        exp_mis = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_illegal(bit st, bit [2:0] f, bit [1:0] a);
    bit bad_code = (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
    bit bad_st   = st && f[2];
    bit half     = (f == 3'b001) || (f == 3'b101);
    bit word     = (f == 3'b010);
    return bad_code || bad_st || (half && a[0]) || (word && (a != 2'd0));
  endfunction

  function automatic int m_nbytes(bit [2:0] f);
    if (f == 3'b010) return 4;
    if (f[0]) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] m_be(bit [2:0] f, bit [1:0] a);
    int n = m_nbytes(f);
    int mask = ((1 << n) - 1) << a;
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(bit [2:0] f, bit [31:0] sd);
    int n = m_nbytes(f);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ext(bit [2:0] f, bit [1:0] a, bit [31:0] rd);
    int n = m_nbytes(f);
    logic [31:0] v = rd >> (8 * a);
    bit sgn = !f[2];
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("mem_req", 32'(mem_if.req), 32'(exp_req));
      chk("load_valid", 32'(load_valid), 32'(exp_lv));
      chk("store_done", 32'(store_done), 32'(exp_sd));
      chk("misaligned", 32'(misaligned), 32'(exp_mis));
      if (exp_req) begin
        chk("mem_we", 32'(mem_if.we), 32'(exp_we));
        chk("mem_addr", mem_if.addr, exp_addr);
        chk("mem_be", 32'(mem_if.be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", mem_if.wdata, exp_wdata);
      end
      if (exp_lv) begin
        chk("load_data", load_data, exp_ld);
        chk("load_tag", 32'(load_tag), 32'(exp_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_agu(input op_t o);
    agu_valid  = 1'b1;
    agu_addr   = o.addr;
    is_store   = o.st;
    funct3     = o.f3;
    store_data = o.sd;
    rd_tag     = o.tag;
  endtask

  task automatic idle_agu();
    agu_valid  = 1'b0;
    agu_addr   = $urandom;
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    store_data = $urandom;
    rd_tag     = 5'($urandom);
  endtask

  // Runs one access, starting in a cycle where the unit is idle.
  task automatic do_op(input op_t o, input op_t nxt, input bit has_nxt);
    drive_agu(o);
    tick();  // accept edge
    if (o.hold && has_nxt) drive_agu(nxt);
    else idle_agu();
    exp_ready = 1'b0;
    if (m_illegal(o.st, o.f3, o.addr[1:0])) begin
      exp_mis = 1'b1;
      tick();
      exp_mis   = 1'b0;
      exp_ready = 1'b1;
    end else begin
      exp_req   = 1'b1;
      exp_we    = o.st;
      exp_addr  = {o.addr[31:2], 2'b00};
      exp_be    = m_be(o.f3, o.addr[1:0]);
      exp_wdata = m_wdata(o.f3, o.sd);
      repeat (o.stall) tick();
      mem_if.gnt = 1'b1;
      if (o.rv_in_req) begin
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = ~o.rdata;
      end
      tick();  // grant edge
      mem_if.gnt    = 1'b0;
      mem_if.rvalid = 1'b0;
      exp_req       = 1'b0;
      if (o.st) begin
        exp_sd = 1'b1;
        tick();
        exp_sd    = 1'b0;
        exp_ready = 1'b1;
      end else begin
        repeat (o.rvd) tick();
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = o.rdata;
        tick();  // rvalid edge
        mem_if.rvalid = 1'b0;
        mem_if.rdata  = $urandom;
        exp_lv  = 1'b1;
        exp_ld  = m_ext(o.f3, o.addr[1:0], o.rdata);
        exp_tag = o.tag;
        tick();
        exp_lv    = 1'b0;
        exp_ready = 1'b1;
      end
    end
    $display("op st=%0d f3=%b addr=%h sd=%h tag=%0d stall=%0d rvd=%0d hold=%0d",
             o.st, o.f3, o.addr, o.sd, o.tag, o.stall, o.rvd, o.hold);
  endtask

  function automatic op_t mk(bit st, bit [2:0] f3, bit [31:0] addr, bit [31:0] sd,
                             bit [4:0] tag, int stall, int rvd, bit [31:0] rdata);
    op_t o;
    o.st = st; o.f3 = f3; o.addr = addr; o.sd = sd; o.tag = tag;
    o.stall = stall; o.rvd = rvd; o.rdata = rdata; o.rv_in_req = 1'b0; o.hold = 1'b0;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int  pick = $urandom_range(0, 9);
    o.st    = 1'($urandom);
    case (pick)
      0, 1:    o.f3 = 3'b000;
      2, 3:    o.f3 = 3'b001;
      4, 5:    o.f3 = 3'b010;
      6:       o.f3 = 3'b100;
      7:       o.f3 = 3'b101;
      default: o.f3 = 3'($urandom);
    endcase
    o.addr  = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      if (o.f3 == 3'b010) o.addr[1:0] = 2'b00;
      if (o.f3[1:0] == 2'b01) o.addr[0] = 1'b0;
    end
    o.sd        = $urandom;
    o.tag       = 5'($urandom);
    o.stall     = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 2);
    o.rvd       = $urandom_range(0, 3);
    o.rdata     = $urandom;
    o.rv_in_req = 1'($urandom_range(0, 3) == 0);
    o.hold      = 1'($urandom);
    return o;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = '0;

    // Pin the model with hand-computed values.
    chk("pin_lb",   m_ext(3'b000, 2'd3, 32'h80FF7F01), 32'hFFFFFF80);
    chk("pin_lbu",  m_ext(3'b100, 2'd3, 32'h80FF7F01), 32'h00000080);
    chk("pin_lh",   m_ext(3'b001, 2'd2, 32'h80FF7F01), 32'hFFFF80FF);
    chk("pin_lhu",  m_ext(3'b101, 2'd0, 32'h80FF7F01), 32'h00007F01);
    chk("pin_sb_be", 32'(m_be(3'b000, 2'd1)), 32'h2);
    chk("pin_sb_wd", m_wdata(3'b000, 32'h12345678), 32'h78787878);
    chk("pin_sh_be", 32'(m_be(3'b001, 2'd2)), 32'hC);
    chk("pin_sh_wd", m_wdata(3'b001, 32'h12345678), 32'h56785678);

    // Reset values.
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_req", 32'(mem_if.req), 32'h0);
    chk("rst_we", 32'(mem_if.we), 32'h0);
    chk("rst_be", 32'(mem_if.be), 32'h0);
    chk("rst_addr", mem_if.addr, 32'h0);
    chk("rst_wdata", mem_if.wdata, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_tag", 32'(load_tag), 32'h0);
    chk("rst_strobes", 32'({load_valid, store_done, misaligned}), 32'h0);
    resetn = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Directed accesses.
    ops.push_back(mk(0, 3'b010, 32'h100, 0, 5'd7, 0, 0, 32'hDEADBEEF));
    ops.push_back(mk(0, 3'b000, 32'h203, 0, 5'd1, 0, 0, 32'h80FF7F01));
    ops.push_back(mk(0, 3'b100, 32'h203, 0, 5'd2, 1, 1, 32'h80FF7F01));
    ops.push_back(mk(0, 3'b001, 32'h202, 0, 5'd3, 0, 2, 32'h80FF7F01));
    ops.push_back(mk(0, 3'b101, 32'h200, 0, 5'd4, 0, 0, 32'h80FF7F01));
    ops.push_back(mk(1, 3'b000, 32'h101, 32'h12345678, 0, 0, 0, 0));
    ops.push_back(mk(1, 3'b001, 32'h102, 32'h12345678, 0, 0, 0, 0));
    ops.push_back(mk(1, 3'b010, 32'h104, 32'h12345678, 0, 4, 0, 0));
    ops.push_back(mk(0, 3'b010, 32'h102, 0, 5'd5, 0, 0, 0));
    ops.push_back(mk(1, 3'b001, 32'h001, 32'hAAAA5555, 0, 0, 0, 0));
    ops.push_back(mk(0, 3'b011, 32'h300, 0, 5'd6, 0, 0, 0));
    for (int i = 0; i < 120; i++) ops.push_back(rnd_op());

    for (int i = 0; i < ops.size(); i++) begin
      if (i + 1 < ops.size()) do_op(ops[i], ops[i + 1], 1'b1);
      else do_op(ops[i], ops[i], 1'b0);
    end
    idle_agu();
    tick();

    // Reset while waiting for read data.
    o = mk(0, 3'b010, 32'h400, 0, 5'd9, 0, 0, 32'h0BADF00D);
    drive_agu(o);
    tick();
    idle_agu();
    exp_ready = 1'b0;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h400; exp_be = 4'hF;
    mem_if.gnt = 1'b1;
    tick();
    mem_if.gnt = 1'b0;
    exp_req = 1'b0;
    tick();  // in WAIT
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_ready = 1'b1;
    chk("wrst_ready", 32'(ready), 32'h1);
    chk("wrst_req", 32'(mem_if.req), 32'h0);
    chk("wrst_we", 32'(mem_if.we), 32'h0);
    chk("wrst_be", 32'(mem_if.be), 32'h0);
    chk("wrst_addr", mem_if.addr, 32'h0);
    chk("wrst_wdata", mem_if.wdata, 32'h0);
    chk("wrst_ld", load_data, 32'h0);
    chk("wrst_tag", 32'(load_tag), 32'h0);
    chk("wrst_strobes", 32'({load_valid, store_done, misaligned}), 32'h0);
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'h0BADF00D;
    tick();  // late rvalid must be ignored
    mem_if.rvalid = 1'b0;
    tick();
    o = mk(0, 3'b010, 32'h404, 0, 5'd10, 1, 1, 32'hCAFEF00D);
    do_op(o, o, 1'b0);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
